poly_mult_sched: RTL

//  Two-requester scheduler/sequencer in front of one shared PolyMult datapath (4 coeff x 8-bit
//  A/B in, 4 coeff x 8-bit C out, start-qualified, fixed latency). Accepts operand pairs via

---
 rtl/poly_mult_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/poly_mult_sched.sv
// Round-robin two-requester sequencer in front of a shared fixed-latency PolyMult datapath.
// Optional per-requester grant counters are enabled by defining POLY_SCHED_STATS_EN.
module poly_mult_sched #(
    parameter int unsigned W        = 8,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [8*W-1:0]     req_a,
    input  logic [8*W-1:0]     req_b,
    output logic               pm_start,
    output logic [4*W-1:0]     pm_a,
    output logic [4*W-1:0]     pm_b,
    input  logic [4*W-1:0]     pm_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_id,
    output logic [4*W-1:0]     out_c,
    output logic               busy,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
);

    localparam int unsigned VW    = 4 * W;
    localparam int unsigned LAT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              id_q, id_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              pm_start_q, pm_start_d;
    logic [VW-1:0]     pm_a_q, pm_a_d;
    logic [VW-1:0]     pm_b_q, pm_b_d;
    logic              out_valid_q, out_valid_d;
    logic              out_id_q, out_id_d;
    logic [VW-1:0]     out_c_q, out_c_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant_c;
    logic              gnt_id_c;

    // Grant only in IDLE and never while reset is asserted; prio requester wins ties.
    always_comb begin
        grant_c = 2'b00;
        if (state_q == S_IDLE && rst) begin
            if (req_valid[prio_q]) begin
                grant_c[prio_q] = 1'b1;
            end else if (req_valid[~prio_q]) begin
                grant_c[~prio_q] = 1'b1;
            end
        end
    end

    assign gnt_id_c  = grant_c[1];
    assign req_ready = grant_c;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        pm_start_d  = 1'b0;
        pm_a_d      = pm_a_q;
        pm_b_d      = pm_b_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_c_d     = out_c_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (|grant_c) begin
                    pm_a_d     = gnt_id_c ? req_a[8*W-1:VW] : req_a[VW-1:0];
                    pm_b_d     = gnt_id_c ? req_b[8*W-1:VW] : req_b[VW-1:0];
                    id_d       = gnt_id_c;
                    prio_d     = ~gnt_id_c;
                    cnt_d      = LAT_W'(MULT_LAT - 1);
                    pm_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            // Counter runs through ISSUE and WAIT so capture lands MULT_LAT edges after grant.
            S_ISSUE, S_WAIT: begin
                if (cnt_q == '0) begin
                    out_c_d     = pm_c;
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d   = cnt_q - LAT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            pm_start_q  <= 1'b0;
            pm_a_q      <= '0;
            pm_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_c_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            pm_start_q  <= pm_start_d;
            pm_a_q      <= pm_a_d;
            pm_b_q      <= pm_b_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_c_q     <= out_c_d;
            busy_q      <= busy_d;
        end
    end

    assign pm_start  = pm_start_q;
    assign pm_a      = pm_a_q;
    assign pm_b      = pm_b_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_c     = out_c_q;
    assign busy      = busy_q;

`ifdef POLY_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Free-running wrap-around grant counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant_c[0]) cnt0_q <= cnt0_q + CNT_W'(1);
            if (grant_c[1]) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
